credit_recv_queue: RTL and testbench

Receiver end of the credit-based flow-control link. The sender tracks its available credits with a saturating up/down counter that starts at p_num_entries. This block sits at the far end of that link:
- it buffers arriving valid-only messages in a circular queue;
- it drains them downstream over a val/rdy interface;
- it returns one single-cycle credit pulse for each entry freed.

It also detects protocol overflow, i.e. a message arriving with no free slot.

---
 rtl/credit_recv_queue_if.sv | 27 ++
 rtl/credit_recv_queue.sv | 66 ++++++
 tb/tb_credit_recv_queue.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/credit_recv_queue_if.sv
// Handshake bundle between the credit-link sender/consumer and the receive queue.
// master = the testbench/sender side, slave = the queue itself.
interface credit_recv_queue_if #(
    parameter int p_msg_nbits   = 32,
    parameter int p_num_entries = 4
);
    localparam int CNT_W = $clog2(p_num_entries + 1);

    logic                   recv_val;
    logic [p_msg_nbits-1:0] recv_msg;
    logic                   send_val;
    logic                   send_rdy;
    logic [p_msg_nbits-1:0] send_msg;
    logic                   credit_return;
    logic [CNT_W-1:0]       num_free;
    logic                   overflow;

    modport master (
        output recv_val, recv_msg, send_rdy,
        input  send_val, send_msg, credit_return, num_free, overflow
    );

    modport slave (
        input  recv_val, recv_msg, send_rdy,
        output send_val, send_msg, credit_return, num_free, overflow
    );
endinterface

// File: rtl/credit_recv_queue.sv
// Receiver end of a credit-based link: circular buffer, val/rdy drain,
// one credit pulse per freed entry, sticky overflow on a dropped message.
module credit_recv_queue #(
    parameter int p_msg_nbits   = 32,
    parameter int p_num_entries = 4
) (
    input  logic               clk,
    input  logic               reset,
    credit_recv_queue_if.slave q
);
    localparam int CNT_W = $clog2(p_num_entries + 1);
    localparam int PTR_W = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
    localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(p_num_entries);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(p_num_entries - 1);

    logic [p_msg_nbits-1:0] mem [p_num_entries];
    logic [PTR_W-1:0]       enq_ptr, deq_ptr;
    logic [CNT_W-1:0]       count, count_next;
    logic                   credit_q, overflow_q;
    logic                   not_empty, enq_fire, deq_fire, drop;

    assign not_empty = (count != '0);
    assign enq_fire  = q.recv_val && (count < DEPTH);
    assign deq_fire  = not_empty && q.send_rdy;
    // A full queue drops the arrival even if a dequeue frees a slot this cycle.
    assign drop      = q.recv_val && (count == DEPTH);

    always_comb begin
        count_next = count;
        if (enq_fire && !deq_fire)
            count_next = count + CNT_W'(1);
        else if (!enq_fire && deq_fire)
            count_next = count - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enq_ptr    <= '0;
            deq_ptr    <= '0;
            count      <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (enq_fire)
                enq_ptr <= (enq_ptr == PTR_LAST) ? '0 : enq_ptr + PTR_W'(1);
            if (deq_fire)
                deq_ptr <= (deq_ptr == PTR_LAST) ? '0 : deq_ptr + PTR_W'(1);
            count    <= count_next;
            credit_q <= deq_fire;
            if (drop)
                overflow_q <= 1'b1;
        end
    end

    // Storage carries no reset; contents are only observed while send_val=1.
    always_ff @(posedge clk) begin
        if (enq_fire)
            mem[enq_ptr] <= q.recv_msg;
    end

    assign q.send_val      = not_empty;
    assign q.send_msg      = mem[deq_ptr];
    assign q.credit_return = credit_q;
    assign q.num_free      = DEPTH - count;
    assign q.overflow      = overflow_q;
endmodule

// File: tb/tb_credit_recv_queue.sv
// Directed bench for credit_recv_queue: depth-4 instance for most scenarios,
// depth-3 instance for pointer wrap with a simple credit-tracking sender.
module tb_credit_recv_queue;
    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] fill_tab [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    credit_recv_queue_if #(.p_msg_nbits(32), .p_num_entries(4)) sa ();
    credit_recv_queue_if #(.p_msg_nbits(32), .p_num_entries(3)) sb ();

    credit_recv_queue #(.p_msg_nbits(32), .p_num_entries(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .q     (sa)
    );

    credit_recv_queue #(.p_msg_nbits(32), .p_num_entries(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .q     (sb)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        sa.recv_val = 1'b1; sa.recv_msg = 32'hDEAD; sa.send_rdy = 1'b1;
        repeat (2) tick();
        n_cmp++; if (sa.send_val !== 1'b0) begin n_err++; $display("FAIL reset_send_val: got %b want 0", sa.send_val); end
        n_cmp++; if (sa.num_free !== 3'd4) begin n_err++; $display("FAIL reset_num_free: got %0d want 4", sa.num_free); end
        n_cmp++; if (sa.credit_return !== 1'b0) begin n_err++; $display("FAIL reset_credit: got %b want 0", sa.credit_return); end
        n_cmp++; if (sa.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", sa.overflow); end
        n_cmp++; if (sb.num_free !== 2'd3) begin n_err++; $display("FAIL reset_num_free_b: got %0d want 3", sb.num_free); end
        sa.recv_val = 1'b0; sa.send_rdy = 1'b0;
        reset = 1'b1;
        // First edge after release enqueues normally.
        for (int i = 0; i < 4; i++) begin
            sa.recv_val = 1'b1; sa.recv_msg = fill_tab[i];
            tick();
            n_cmp++; if (sa.num_free !== 3'(3 - i)) begin n_err++; $display("FAIL fill_num_free[%0d]: got %0d want %0d", i, sa.num_free, 3 - i); end
            n_cmp++; if (sa.send_val !== 1'b1 || sa.send_msg !== 32'h11) begin n_err++; $display("FAIL fill_head[%0d]: got val=%b msg=%h want val=1 msg=11", i, sa.send_val, sa.send_msg); end
        end
        sa.recv_val = 1'b0;
    endtask

    task automatic test_drain();
        int   pulses = 0;
        logic ec;
        sa.send_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ec = (i > 0);
            n_cmp++; if (sa.send_val !== 1'b1 || sa.send_msg !== fill_tab[i]) begin n_err++; $display("FAIL drain_msg[%0d]: got val=%b msg=%h want val=1 msg=%h", i, sa.send_val, sa.send_msg, fill_tab[i]); end
            n_cmp++; if (sa.credit_return !== ec) begin n_err++; $display("FAIL drain_credit[%0d]: got %b want %b", i, sa.credit_return, ec); end
            if (sa.credit_return === 1'b1) pulses++;
            tick();
        end
        if (sa.credit_return === 1'b1) pulses++;
        n_cmp++; if (sa.send_val !== 1'b0 || sa.num_free !== 3'd4) begin n_err++; $display("FAIL drain_empty: got val=%b free=%0d want val=0 free=4", sa.send_val, sa.num_free); end
        sa.send_rdy = 1'b0;
        tick();
        if (sa.credit_return === 1'b1) pulses++;
        n_cmp++; if (pulses !== 4) begin n_err++; $display("FAIL drain_pulses: got %0d want 4", pulses); end
    endtask

    task automatic test_stream();
        logic ec;
        sa.recv_val = 1'b1; sa.send_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sa.recv_msg = 32'h100 + 32'(k);
            tick();
            ec = (k > 0);
            n_cmp++; if (sa.send_val !== 1'b1 || sa.send_msg !== 32'h100 + 32'(k)) begin n_err++; $display("FAIL stream_msg[%0d]: got val=%b msg=%h want val=1 msg=%h", k, sa.send_val, sa.send_msg, 32'h100 + 32'(k)); end
            n_cmp++; if (sa.num_free !== 3'd3 || sa.credit_return !== ec || sa.overflow !== 1'b0) begin n_err++; $display("FAIL stream_state[%0d]: got free=%0d cr=%b ovf=%b want free=3 cr=%b ovf=0", k, sa.num_free, sa.credit_return, sa.overflow, ec); end
        end
        sa.recv_val = 1'b0;
        tick();
        n_cmp++; if (sa.send_val !== 1'b0 || sa.credit_return !== 1'b1 || sa.num_free !== 3'd4) begin n_err++; $display("FAIL stream_tail: got val=%b cr=%b free=%0d want 0 1 4", sa.send_val, sa.credit_return, sa.num_free); end
        sa.send_rdy = 1'b0;
        tick();
        n_cmp++; if (sa.credit_return !== 1'b0) begin n_err++; $display("FAIL stream_idle_credit: got %b want 0", sa.credit_return); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_q [$];
        logic [15:0] stall = 16'b1011_0110_0101_1101;
        int credits = 3, sent = 0, got = 0, pulses = 0, cyc = 0;
        while ((got < 10 || pulses < 10) && cyc < 200) begin
            if (sb.credit_return === 1'b1) begin credits++; pulses++; end
            sb.send_rdy = stall[cyc % 16];
            if (sb.send_val === 1'b1 && sb.send_rdy) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL wrap_spurious: got msg=%h want no entry", sb.send_msg);
                end else begin
                    if (sb.send_msg !== exp_q[0]) begin n_err++; $display("FAIL wrap_msg[%0d]: got %h want %h", got, sb.send_msg, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            if (credits > 0 && sent < 10) begin
                sb.recv_val = 1'b1; sb.recv_msg = 32'h200 + 32'(sent);
                exp_q.push_back(32'h200 + 32'(sent));
                sent++; credits--;
            end else begin
                sb.recv_val = 1'b0;
            end
            tick();
            cyc++;
        end
        sb.recv_val = 1'b0; sb.send_rdy = 1'b0;
        n_cmp++; if (got !== 10) begin n_err++; $display("FAIL wrap_count: got %0d want 10", got); end
        n_cmp++; if (pulses !== 10) begin n_err++; $display("FAIL wrap_pulses: got %0d want 10", pulses); end
        tick();
        n_cmp++; if (sb.num_free !== 2'd3 || sb.overflow !== 1'b0 || sb.credit_return !== 1'b0) begin n_err++; $display("FAIL wrap_final: got free=%0d ovf=%b cr=%b want 3 0 0", sb.num_free, sb.overflow, sb.credit_return); end
    endtask

    task automatic test_overflow();
        int pulses = 0;
        sa.send_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sa.recv_val = 1'b1; sa.recv_msg = 32'hA0 + 32'(i);
            tick();
        end
        // Arrival against a full queue while the head is also leaving.
        sa.recv_val = 1'b1; sa.recv_msg = 32'hBAD; sa.send_rdy = 1'b1;
        tick();
        sa.recv_val = 1'b0;
        n_cmp++; if (sa.num_free !== 3'd1) begin n_err++; $display("FAIL ovf_num_free: got %0d want 1", sa.num_free); end
        for (int i = 1; i < 4; i++) begin
            n_cmp++; if (sa.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag[%0d]: got %b want 1", i, sa.overflow); end
            n_cmp++; if (sa.send_val !== 1'b1 || sa.send_msg !== 32'hA0 + 32'(i)) begin n_err++; $display("FAIL ovf_msg[%0d]: got val=%b msg=%h want val=1 msg=%h", i, sa.send_val, sa.send_msg, 32'hA0 + 32'(i)); end
            if (sa.credit_return === 1'b1) pulses++;
            tick();
        end
        if (sa.credit_return === 1'b1) pulses++;
        n_cmp++; if (sa.send_val !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got val=%b msg=%h want val=0", sa.send_val, sa.send_msg); end
        tick();
        if (sa.credit_return === 1'b1) pulses++;
        n_cmp++; if (pulses !== 4) begin n_err++; $display("FAIL ovf_pulses: got %0d want 4", pulses); end
        sa.recv_val = 1'b1; sa.recv_msg = 32'h55;
        tick();
        sa.recv_val = 1'b0;
        n_cmp++; if (sa.send_msg !== 32'h55 || sa.send_val !== 1'b1) begin n_err++; $display("FAIL ovf_later_msg: got val=%b msg=%h want val=1 msg=55", sa.send_val, sa.send_msg); end
        repeat (2) tick();
        n_cmp++; if (sa.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", sa.overflow); end
        sa.send_rdy = 1'b0;
    endtask

    task automatic test_reset_mid();
        sa.send_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sa.recv_val = 1'b1; sa.recv_msg = 32'h71 + 32'(i);
            tick();
        end
        sa.recv_val = 1'b0; sa.send_rdy = 1'b1;
        tick();
        sa.send_rdy = 1'b0;
        n_cmp++; if (sa.credit_return !== 1'b1 || sa.num_free !== 3'd2) begin n_err++; $display("FAIL rmid_pre: got cr=%b free=%0d want cr=1 free=2", sa.credit_return, sa.num_free); end
        reset = 1'b0;
        #1;
        n_cmp++; if (sa.credit_return !== 1'b0) begin n_err++; $display("FAIL rmid_credit: got %b want 0", sa.credit_return); end
        n_cmp++; if (sa.send_val !== 1'b0 || sa.num_free !== 3'd4 || sa.overflow !== 1'b0) begin n_err++; $display("FAIL rmid_state: got val=%b free=%0d ovf=%b want 0 4 0", sa.send_val, sa.num_free, sa.overflow); end
        #1;
        reset = 1'b1;
        tick();
        n_cmp++; if (sa.send_val !== 1'b0 || sa.credit_return !== 1'b0) begin n_err++; $display("FAIL rmid_after: got val=%b cr=%b want 0 0", sa.send_val, sa.credit_return); end
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b0;
        sa.recv_val = 1'b0; sa.recv_msg = '0; sa.send_rdy = 1'b0;
        sb.recv_val = 1'b0; sb.recv_msg = '0; sb.send_rdy = 1'b0;
        test_reset();
        test_drain();
        test_stream();
        test_wrap();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
